// File: rtl/pulse_pkg.sv
// Shared definitions for the instruction-cycle pulse sequencer.
// The state encoding is exported so debug/console logic can decode it.
package pulse_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        OP_REQ  = 3'd3,
        OP_WAIT = 3'd4,
        WR_REQ  = 3'd5,
        WR_WAIT = 3'd6
    } pulse_state_e;

endpackage

// File: rtl/pulse.sv
// Machine-cycle sequencer: memory read, operate, memory write, each issued as a
// one-cycle request strobe followed by a wait for its one-cycle completion.
module pulse
    import pulse_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic start_pulse,
    output logic mem_read_pulse,
    output logic mem_write_pulse,
    input  logic mem_reply,
    output logic operate_pulse,
    input  logic operate_reply
);

    // Handshake: each request is high for exactly the one cycle the FSM spends
    // in its REQ state; a reply is accepted only while in the matching WAIT
    // state, so a reply coincident with its own request strobe is dropped.
    pulse_state_e state_q, state_d;
    logic         mem_read_q, mem_read_d;
    logic         operate_q, operate_d;
    logic         mem_write_q, mem_write_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_pulse)   state_d = RD_REQ;
            RD_REQ:                     state_d = RD_WAIT;
            RD_WAIT: if (mem_reply)     state_d = OP_REQ;
            OP_REQ:                     state_d = OP_WAIT;
            OP_WAIT: if (operate_reply) state_d = WR_REQ;
            WR_REQ:                     state_d = WR_WAIT;
            WR_WAIT: if (mem_reply)     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase

        // Outputs are registered copies of "entering a REQ state".
        mem_read_d  = (state_d == RD_REQ);
        operate_d   = (state_d == OP_REQ);
        mem_write_d = (state_d == WR_REQ);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            operate_q   <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            operate_q   <= operate_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign mem_read_pulse  = mem_read_q;
    assign operate_pulse   = operate_q;
    assign mem_write_pulse = mem_write_q;

endmodule

// File: tb/tb_pulse.sv
// Directed bench for the pulse sequencer: inputs change and outputs are checked
// on the falling edge; each check reflects the state after the preceding rise.
module tb_pulse;
  import pulse_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic start_pulse = 1'b0;
  logic mem_reply = 1'b0;
  logic operate_reply = 1'b0;
  logic mem_read_pulse;
  logic mem_write_pulse;
  logic operate_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;

  pulse dut (
    .clk            (clk),
    .resetn         (resetn),
    .start_pulse    (start_pulse),
    .mem_read_pulse (mem_read_pulse),
    .mem_write_pulse(mem_write_pulse),
    .mem_reply      (mem_reply),
    .operate_pulse  (operate_pulse),
    .operate_reply  (operate_reply)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // count every cycle in which a request strobe was high
  always @(posedge clk) begin
    strobes = strobes + int'(mem_read_pulse) + int'(operate_pulse) + int'(mem_write_pulse);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic rd, input logic op, input logic wr);
    n_cmp++;
    assert ({mem_read_pulse, operate_pulse, mem_write_pulse} === {rd, op, wr})
    else begin
      n_bad++;
      $error("FAIL %s: observed rd/op/wr=%b%b%b expected %b%b%b", tag,
             mem_read_pulse, operate_pulse, mem_write_pulse, rd, op, wr);
    end
  endtask

  task automatic check_state(input string tag, input pulse_state_e s);
    n_cmp++;
    assert (dut.state_q === s)
    else begin
      n_bad++;
      $error("FAIL %s: observed state=%0d expected %0d", tag, dut.state_q, s);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_phase(input string tag, input int n, input pulse_state_e s);
    for (int i = 0; i < n; i++) begin
      tick();
      check_out(tag, 1'b0, 1'b0, 1'b0);
      check_state(tag, s);
    end
  endtask

  // one complete machine cycle, each reply arriving after dly idle WAIT cycles
  task automatic full_cycle(input string tag, input int dly);
    int s0;
    s0 = strobes;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    check_out({tag, "_rd"}, 1'b1, 1'b0, 1'b0);
    wait_phase({tag, "_rdw"}, dly, RD_WAIT);
    mem_reply = 1'b1;
    tick();
    mem_reply = 1'b0;
    check_out({tag, "_op"}, 1'b0, 1'b1, 1'b0);
    wait_phase({tag, "_opw"}, dly, OP_WAIT);
    operate_reply = 1'b1;
    tick();
    operate_reply = 1'b0;
    check_out({tag, "_wr"}, 1'b0, 1'b0, 1'b1);
    wait_phase({tag, "_wrw"}, dly, WR_WAIT);
    mem_reply = 1'b1;
    tick();
    mem_reply = 1'b0;
    check_out({tag, "_done"}, 1'b0, 1'b0, 1'b0);
    check_state({tag, "_idle"}, IDLE);
    check_int({tag, "_strobes"}, strobes - s0, 3);
  endtask

  initial begin
    // reset, then quiet idle with stray replies
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    check_out("reset", 1'b0, 1'b0, 1'b0);
    check_state("reset_state", IDLE);
    wait_phase("idle", 5, IDLE);
    mem_reply = 1'b1;
    tick();
    mem_reply = 1'b0;
    check_out("stray_mem", 1'b0, 1'b0, 1'b0);
    check_state("stray_mem_st", IDLE);
    operate_reply = 1'b1;
    tick();
    operate_reply = 1'b0;
    check_out("stray_op", 1'b0, 1'b0, 1'b0);
    check_state("stray_op_st", IDLE);

    // normal cycle with short reply delay, then long delay
    full_cycle("fast", 1);
    full_cycle("slow", 10);

    // reply during its own request strobe is dropped; start during RD_WAIT is ignored
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    check_out("ign_rd", 1'b1, 1'b0, 1'b0);
    mem_reply = 1'b1;
    tick();
    mem_reply = 1'b0;
    check_out("req_reply", 1'b0, 1'b0, 1'b0);
    check_state("req_reply_st", RD_WAIT);
    start_pulse = 1'b1;
    operate_reply = 1'b1;
    tick();
    start_pulse = 1'b0;
    operate_reply = 1'b0;
    check_out("start_in_wait", 1'b0, 1'b0, 1'b0);
    check_state("start_in_wait_st", RD_WAIT);
    // held mem_reply: one state per edge, then ignored in OP_WAIT
    mem_reply = 1'b1;
    tick();
    check_out("held_op", 1'b0, 1'b1, 1'b0);
    tick();
    check_out("held_opw", 1'b0, 1'b0, 1'b0);
    check_state("held_opw_st", OP_WAIT);
    tick();
    mem_reply = 1'b0;
    check_out("mem_in_opw", 1'b0, 1'b0, 1'b0);
    check_state("mem_in_opw_st", OP_WAIT);
    operate_reply = 1'b1;
    tick();
    operate_reply = 1'b0;
    check_out("ign_wr", 1'b0, 1'b0, 1'b1);
    operate_reply = 1'b1;
    tick();
    tick();
    operate_reply = 1'b0;
    check_out("op_in_wrw", 1'b0, 1'b0, 1'b0);
    check_state("op_in_wrw_st", WR_WAIT);
    mem_reply = 1'b1;
    start_pulse = 1'b1;
    tick();
    mem_reply = 1'b0;
    start_pulse = 1'b0;
    check_out("ign_done", 1'b0, 1'b0, 1'b0);
    check_state("ign_done_st", IDLE);
    tick();
    check_out("start_with_done", 1'b0, 1'b0, 1'b0);
    check_state("start_with_done_st", IDLE);

    // reset in OP_WAIT abandons the handshake
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    tick();
    mem_reply = 1'b1;
    tick();
    mem_reply = 1'b0;
    tick();
    check_state("pre_rst_st", OP_WAIT);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    check_out("mid_rst", 1'b0, 1'b0, 1'b0);
    check_state("mid_rst_st", IDLE);
    operate_reply = 1'b1;
    tick();
    operate_reply = 1'b0;
    check_out("late_reply", 1'b0, 1'b0, 1'b0);
    check_state("late_reply_st", IDLE);
    full_cycle("after_rst", 2);

    // back-to-back: second start one cycle after the final mem_reply
    full_cycle("b2b_a", 1);
    full_cycle("b2b_b", 1);

    // start held high through a whole cycle restarts once IDLE is re-entered
    start_pulse = 1'b1;
    tick();
    check_out("held_start_rd", 1'b1, 1'b0, 1'b0);
    tick();
    check_out("held_start_rdw", 1'b0, 1'b0, 1'b0);
    mem_reply = 1'b1;
    tick();
    mem_reply = 1'b0;
    tick();
    operate_reply = 1'b1;
    tick();
    operate_reply = 1'b0;
    check_out("held_start_wr", 1'b0, 1'b0, 1'b1);
    tick();
    mem_reply = 1'b1;
    tick();
    mem_reply = 1'b0;
    check_state("held_start_idle", IDLE);
    tick();
    start_pulse = 1'b0;
    check_out("held_start_again", 1'b1, 1'b0, 1'b0);
    check_state("held_start_again_st", RD_REQ);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    check_out("final_rst", 1'b0, 1'b0, 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
